pipe_ctrl_unit: RTL and testbench

Parametrised pipeline control unit. It generates the per-stage stall vector and the exception flush/redirect for the in-order MIPS pipeline.
- Generalised over stage count, stall-source count and per-source stall depth, all set by parameters.
- Holds exceptions that arrive while a blocking source (cache/memory miss) is active and replays them as a flush once the block clears.
- Adds a consecutive-stall counter and a watchdog.
- Sits beside the pipeline stages; receives requests from ID/EX/MEM/CP0 and the exception target PC from CP0.

---
 rtl/pipe_ctrl_unit.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_unit
//   Pipeline control for the in-order MIPS pipeline. It builds the per-stage
//   stall vector from the stall request sources and issues the exception
//   flush/redirect. An exception that arrives while a blocking source such as
//   a cache miss is active is held. It is replayed as a flush once the block
//   clears. The unit also counts consecutive stall cycles and raises a
//   watchdog when that count gets too high.
//
//   Optional build macro: PIPE_CTRL_PERF_EN
//     When defined, the unit keeps one 32-bit stall-request counter per
//     source, and perf_sel_i selects which one drives perf_cnt_o.
//     When undefined, perf_cnt_o is 0.
//
// Ports
//   clk            system clock
//   resetn         asynchronous active-low reset
//   stallreq_i     per-source stall request (level)
//   excp_valid_i   exception/eret redirect request (pulse)
//   excp_pc_i      redirect target, valid with excp_valid_i
//   flush          pipeline flush
//   new_pc         redirect PC while flush=1, else 0
//   stall          per-stage stall vector; bit 0 = PC/IF, rising toward WB
//   excp_pending_o a deferred exception is held
//   stall_cnt_o    consecutive stall cycles, saturating
//   wdog_o         watchdog hit (registered)
//   perf_sel_i     performance counter select
//   perf_cnt_o     selected performance counter
// ----------------------------------------------------------------------------
module pipe_ctrl_unit #(
    parameter int                              NUM_STAGES = 6,
    parameter int                              NUM_REQ    = 5,
    parameter logic [NUM_STAGES*NUM_REQ-1:0]   STALL_MAP  = 30'b000011_000111_000111_001111_011111,
    parameter logic [NUM_REQ-1:0]              BLOCK_MASK = 5'b00001,
    parameter int                              CNT_W      = 16,
    parameter int unsigned                     WDOG_LIMIT = 4096,
    localparam int                             SEL_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    stallreq_i,
    input  logic                  excp_valid_i,
    input  logic [31:0]           excp_pc_i,
    output logic                  flush,
    output logic [31:0]           new_pc,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  excp_pending_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic                  wdog_o,
    input  logic [SEL_W-1:0]      perf_sel_i,
    output logic [31:0]           perf_cnt_o
);

    logic [NUM_STAGES-1:0] stall_raw;
    logic                  blk;
    logic                  flush_raw;
    logic [31:0]           new_pc_raw;

    logic                  pend_v_q, pend_v_d;
    logic [31:0]           pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                  wdog_q, wdog_d;
    logic [CNT_W:0]        cnt_inc;

    // The masks are thermometer codes, so ORing them gives the deepest
    // requested stall.
    always_comb begin
        stall_raw = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stallreq_i[i]) stall_raw = stall_raw | STALL_MAP[i*NUM_STAGES +: NUM_STAGES];
        end
    end

    assign blk = |(stallreq_i & BLOCK_MASK);

    // Flush priority. A block defers all flushing. A held exception beats a
    // new one. A request that arrives while a held exception is replayed is
    // dropped, because that flush already wipes the pipeline.
    always_comb begin
        flush_raw  = 1'b0;
        new_pc_raw = '0;
        pend_v_d   = pend_v_q;
        pend_pc_d  = pend_pc_q;
        if (blk) begin
            if (excp_valid_i && !pend_v_q) begin
                pend_v_d  = 1'b1;
                pend_pc_d = excp_pc_i;
            end
        end else if (pend_v_q) begin
            flush_raw  = 1'b1;
            new_pc_raw = pend_pc_q;
            pend_v_d   = 1'b0;
        end else if (excp_valid_i) begin
            flush_raw  = 1'b1;
            new_pc_raw = excp_pc_i;
        end
    end

    // While reset is held, the combinational outputs are forced quiet.
    assign stall  = resetn ? stall_raw  : '0;
    assign flush  = resetn & flush_raw;
    assign new_pc = resetn ? new_pc_raw : '0;

    // The watchdog compares against the count including this cycle. That
    // count is one bit wider than the counter, so saturation cannot hide it.
    assign cnt_inc = {1'b0, stall_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        stall_cnt_d = '0;
        wdog_d      = 1'b0;
        if (stall != '0) begin
            stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : cnt_inc[CNT_W-1:0];
            wdog_d      = wdog_q || (32'(cnt_inc) >= WDOG_LIMIT);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_v_q    <= 1'b0;
            pend_pc_q   <= '0;
            stall_cnt_q <= '0;
            wdog_q      <= 1'b0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_pc_q   <= pend_pc_d;
            stall_cnt_q <= stall_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign excp_pending_o = pend_v_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign wdog_o         = wdog_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [NUM_REQ-1:0][31:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_cnt_d[i] = perf_cnt_q[i] + {31'd0, stallreq_i[i]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) perf_cnt_q <= '0;
        else         perf_cnt_q <= perf_cnt_d;
    end

    // An out-of-range select matches no counter and reads as 0.
    always_comb begin
        perf_cnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (perf_sel_i == SEL_W'(i)) perf_cnt_o = perf_cnt_q[i];
        end
    end
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^perf_sel_i;
    assign perf_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;

    logic        clk;
    logic        resetn;
    logic [4:0]  stallreq_i;
    logic        excp_valid_i;
    logic [31:0] excp_pc_i;
    logic [2:0]  perf_sel_i;

    logic        flush, flush2;
    logic [31:0] new_pc, new_pc2;
    logic [5:0]  stall, stall2;
    logic        pend, pend2;
    logic [15:0] cnt;
    logic [2:0]  cnt2;
    logic        wdog, wdog2;
    logic [31:0] perf, perf2;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_unit #(.WDOG_LIMIT(8)) dut (
        .clk(clk), .resetn(resetn), .stallreq_i(stallreq_i),
        .excp_valid_i(excp_valid_i), .excp_pc_i(excp_pc_i),
        .flush(flush), .new_pc(new_pc), .stall(stall),
        .excp_pending_o(pend), .stall_cnt_o(cnt), .wdog_o(wdog),
        .perf_sel_i(perf_sel_i), .perf_cnt_o(perf)
    );

    // A narrow-counter build is used for the saturation check.
    pipe_ctrl_unit #(.CNT_W(3), .WDOG_LIMIT(5)) dut_sat (
        .clk(clk), .resetn(resetn), .stallreq_i(stallreq_i),
        .excp_valid_i(excp_valid_i), .excp_pc_i(excp_pc_i),
        .flush(flush2), .new_pc(new_pc2), .stall(stall2),
        .excp_pending_o(pend2), .stall_cnt_o(cnt2), .wdog_o(wdog2),
        .perf_sel_i(perf_sel_i), .perf_cnt_o(perf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge. Outputs are sampled 1 time unit
    // later, well away from the rising edge.
    task automatic drive(input logic [4:0] req, input logic ev, input logic [31:0] pc);
        stallreq_i   = req;
        excp_valid_i = ev;
        excp_pc_i    = pc;
        #1;
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0]  req;
        logic        ev;
        logic [31:0] pc;
        logic [5:0]  exp_stall;
        logic        exp_flush;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{5'b10010, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0};
        vecs[1] = '{5'b10000, 1'b0, 32'h0,        6'b000011, 1'b0, 32'h0};
        vecs[2] = '{5'b00000, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0};
        vecs[3] = '{5'b00001, 1'b0, 32'h0,        6'b011111, 1'b0, 32'h0};
        vecs[4] = '{5'b00100, 1'b0, 32'h0,        6'b000111, 1'b0, 32'h0};
        vecs[5] = '{5'b01000, 1'b0, 32'h0,        6'b000111, 1'b0, 32'h0};
        vecs[6] = '{5'b11111, 1'b0, 32'h0,        6'b011111, 1'b0, 32'h0};
        vecs[7] = '{5'b00010, 1'b1, 32'hBFC00380, 6'b001111, 1'b1, 32'hBFC00380};
        vecs[8] = '{5'b00000, 1'b1, 32'h12345678, 6'b000000, 1'b1, 32'h12345678};
        vecs[9] = '{5'b00000, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0};

        perf_sel_i = 3'd0;
        resetn     = 1'b0;
        @(negedge clk);

        // Reset: the outputs are forced low even with active inputs.
        drive(5'b11111, 1'b1, 32'hDEADBEEF);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_flush", 64'(flush), 64'h0);
        chk("rst_newpc", 64'(new_pc), 64'h0);
        chk("rst_pend",  64'(pend), 64'h0);
        chk("rst_cnt",   64'(cnt), 64'h0);
        chk("rst_wdog",  64'(wdog), 64'h0);
        chk("rst_perf",  64'(perf), 64'h0);
        drive(5'b0, 1'b0, 32'h0);
        next_cyc();
        resetn = 1'b1;
        next_cyc();

        // Table-driven combinational vectors.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].req, vecs[i].ev, vecs[i].pc);
            chk($sformatf("vec%0d_stall", i), 64'(stall),  64'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_flush", i), 64'(flush),  64'(vecs[i].exp_flush));
            chk($sformatf("vec%0d_newpc", i), 64'(new_pc), 64'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_pend", i),  64'(pend),   64'h0);
            next_cyc();
        end

        // Direct flush, followed by a quiet cycle.
        drive(5'b0, 1'b1, 32'hBFC00380);
        chk("dir_flush", 64'(flush), 64'h1);
        chk("dir_newpc", 64'(new_pc), 64'hBFC00380);
        next_cyc();
        drive(5'b0, 1'b0, 32'h0);
        chk("dir_flush_off", 64'(flush), 64'h0);
        chk("dir_newpc_off", 64'(new_pc), 64'h0);
        next_cyc();

        // Deferred flush: source 0 blocks for 5 cycles, with an exception at cycle 2.
        for (int c = 0; c < 5; c++) begin
            drive(5'b00001, c == 2, (c == 2) ? 32'h80000180 : 32'h0);
            chk($sformatf("def_c%0d_flush", c), 64'(flush), 64'h0);
            chk($sformatf("def_c%0d_newpc", c), 64'(new_pc), 64'h0);
            chk($sformatf("def_c%0d_pend", c),  64'(pend), (c > 2) ? 64'h1 : 64'h0);
            next_cyc();
        end
        drive(5'b0, 1'b0, 32'h0);
        chk("def_rel_flush", 64'(flush), 64'h1);
        chk("def_rel_newpc", 64'(new_pc), 64'h80000180);
        next_cyc();
        drive(5'b0, 1'b0, 32'h0);
        chk("def_after_flush", 64'(flush), 64'h0);
        chk("def_after_pend",  64'(pend), 64'h0);
        next_cyc();

        // The older exception wins, and a request during the replay is dropped.
        drive(5'b00001, 1'b1, 32'h100); next_cyc();
        drive(5'b00001, 1'b1, 32'h200); next_cyc();
        drive(5'b00001, 1'b0, 32'h0);
        chk("old_pend", 64'(pend), 64'h1);
        next_cyc();
        drive(5'b0, 1'b1, 32'h300);
        chk("old_rel_flush", 64'(flush), 64'h1);
        chk("old_rel_newpc", 64'(new_pc), 64'h100);
        next_cyc();
        drive(5'b0, 1'b0, 32'h0);
        chk("old_after_flush", 64'(flush), 64'h0);
        chk("old_after_pend",  64'(pend), 64'h0);
        next_cyc();

        // Watchdog (limit 8) and saturation (3-bit counter, limit 5).
        for (int k = 0; k < 10; k++) begin
            drive(5'b00010, 1'b0, 32'h0);
            chk($sformatf("wd_k%0d_cnt", k),   64'(cnt),   64'(k));
            chk($sformatf("wd_k%0d_wdog", k),  64'(wdog),  (k >= 8) ? 64'h1 : 64'h0);
            chk($sformatf("wd_k%0d_cnt3", k),  64'(cnt2),  (k > 7) ? 64'd7 : 64'(k));
            chk($sformatf("wd_k%0d_wdog3", k), 64'(wdog2), (k >= 5) ? 64'h1 : 64'h0);
            next_cyc();
        end
        drive(5'b0, 1'b0, 32'h0);
        chk("wd_rel_cnt",  64'(cnt), 64'd10);
        chk("wd_rel_wdog", 64'(wdog), 64'h1);
        chk("wd_rel_cnt3", 64'(cnt2), 64'd7);
        next_cyc();
        drive(5'b0, 1'b0, 32'h0);
        chk("wd_clr_cnt",  64'(cnt), 64'h0);
        chk("wd_clr_wdog", 64'(wdog), 64'h0);
        chk("wd_clr_wdog3", 64'(wdog2), 64'h0);
        next_cyc();

        // Reset in the middle of a block while an exception is pending.
        drive(5'b00001, 1'b1, 32'h400); next_cyc();
        drive(5'b00001, 1'b0, 32'h0);
        chk("mid_pend", 64'(pend), 64'h1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_stall", 64'(stall), 64'h0);
        chk("mid_rst_flush", 64'(flush), 64'h0);
        chk("mid_rst_pend",  64'(pend), 64'h0);
        chk("mid_rst_cnt",   64'(cnt), 64'h0);
        next_cyc();
        resetn = 1'b1;
        drive(5'b0, 1'b0, 32'h0);
        chk("mid_rel_flush", 64'(flush), 64'h0);
        chk("mid_rel_newpc", 64'(new_pc), 64'h0);
        next_cyc();
        drive(5'b0, 1'b0, 32'h0);
        chk("mid_rel2_flush", 64'(flush), 64'h0);
        chk("mid_rel2_pend",  64'(pend), 64'h0);

        // Perf counters: source 2 requests for 3 cycles after the reset.
        for (int c = 0; c < 3; c++) begin
            next_cyc();
            drive(5'b00100, 1'b0, 32'h0);
        end
        next_cyc();
        drive(5'b0, 1'b0, 32'h0);
        perf_sel_i = 3'd2;
        #1;
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_sel2", 64'(perf), 64'd3);
`else
        chk("perf_sel2", 64'(perf), 64'd0);
`endif
        perf_sel_i = 3'd0;
        #1;
        chk("perf_sel0", 64'(perf), 64'd0);
        perf_sel_i = 3'd5;
        #1;
        chk("perf_sel_oor", 64'(perf), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
